// File: rtl/riscv_defines.sv
// -----------------------------------------------------------------------------
// riscv_defines
// Shared types and constants for the memory-port arbiter slice.
//   WORD_WIDTH   : address/data width of the core memory interfaces
//   arb_state_t  : arbiter FSM state encoding
//   arb_owner_t  : which master currently owns the shared memory port
// -----------------------------------------------------------------------------
package riscv_defines;

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_WAIT_GNT    = 2'd1,
        ARB_WAIT_RVALID = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// -----------------------------------------------------------------------------
// mem_arb_select
// Combinational owner picker for the memory-port arbiter.
// A lone requester always wins. On contention:
//   MEM_ARB_ROUND_ROBIN_EN defined : the master that was not granted last wins
//   MEM_ARB_ROUND_ROBIN_EN undefined (default) : DATA always wins
// Ports:
//   instr_req : fetch request (already qualified by the arbiter enable)
//   data_req  : load/store request (already qualified by the arbiter enable)
//   last_q    : master granted most recently
//   owner     : selected owner (OWNER_INSTR when nobody requests)
// -----------------------------------------------------------------------------
module mem_arb_select
    import riscv_defines::*;
(
    input  logic       instr_req,
    input  logic       data_req,
    input  arb_owner_t last_q,
    output arb_owner_t owner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority does not look at history.
    logic unused_last_s;
    assign unused_last_s = last_q;
`endif

    // Owner selection: single requester wins, contention resolved by build option.
    always_comb begin
        owner = OWNER_INSTR;
        if (instr_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_q == OWNER_INSTR) begin
                owner = OWNER_DATA;
            end else begin
                owner = OWNER_INSTR;
            end
`else
            owner = OWNER_DATA;
`endif
        end else if (data_req) begin
            owner = OWNER_DATA;
        end else begin
            owner = OWNER_INSTR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Lets the fetch unit (instr_*) and the load/store path (data_*) share one
// memory port (mem_*) with the req/gnt/rvalid protocol on all sides. At most
// one transaction is outstanding. Contention policy is selected by the macro
// MEM_ARB_ROUND_ROBIN_EN (defined: round-robin, undefined: data first).
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   instr_req_i/addr_i            : fetch request, held until instr_gnt_o
//   instr_gnt_o/rvalid_o/rdata_o  : fetch grant and response
//   data_req_i/addr_i/we_i/be_i/wdata_i : load/store request
//   data_gnt_o/rvalid_o/rdata_o   : load/store grant and response
//   mem_req_o/addr_o/we_o/be_o/wdata_o  : shared-port request
//   mem_gnt_i/rvalid_i/rdata_i    : shared-port response
// Grants and rvalids are combinational from mem_gnt_i/mem_rvalid_i;
// mem_req_o never depends on mem_gnt_i or mem_rvalid_i.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  instr_req_i,
    input  logic [WORD_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,

    input  logic                  data_req_i,
    input  logic [WORD_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [WORD_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [WORD_WIDTH-1:0] data_rdata_o,

    output logic                  mem_req_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i
);

    import riscv_defines::*;

    arb_state_t state_q;
    arb_state_t state_d;
    arb_owner_t owner_q;
    arb_owner_t last_q;
    logic       arb_en_q;

    logic       instr_req_s;
    logic       data_req_s;
    arb_owner_t sel_owner_s;
    arb_owner_t cur_owner_s;
    logic       mem_req_s;
    logic       grant_s;
    logic       resp_s;

    // Requests are invisible until the first clock after reset release.
    assign instr_req_s = instr_req_i & arb_en_q;
    assign data_req_s  = data_req_i  & arb_en_q;

    mem_arb_select u_select (
        .instr_req (instr_req_s),
        .data_req  (data_req_s),
        .last_q    (last_q),
        .owner     (sel_owner_s)
    );

    // Port request and current owner: free choice in IDLE, locked afterwards.
    always_comb begin
        mem_req_s   = 1'b0;
        cur_owner_s = owner_q;
        case (state_q)
            ARB_IDLE: begin
                mem_req_s   = instr_req_s | data_req_s;
                cur_owner_s = sel_owner_s;
            end
            ARB_WAIT_GNT: begin
                mem_req_s   = 1'b1;
                cur_owner_s = owner_q;
            end
            ARB_WAIT_RVALID: begin
                mem_req_s   = 1'b0;
                cur_owner_s = owner_q;
            end
            default: begin
                mem_req_s   = 1'b0;
                cur_owner_s = owner_q;
            end
        endcase
    end

    // A grant only counts while we request; rvalid only while one is outstanding.
    assign grant_s = mem_req_s & mem_gnt_i;
    assign resp_s  = (state_q == ARB_WAIT_RVALID) & mem_rvalid_i;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req_s) begin
                    if (mem_gnt_i) begin
                        state_d = ARB_WAIT_RVALID;
                    end else begin
                        state_d = ARB_WAIT_GNT;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_GNT: begin
                if (mem_gnt_i) begin
                    state_d = ARB_WAIT_RVALID;
                end else begin
                    state_d = ARB_WAIT_GNT;
                end
            end
            ARB_WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT_RVALID;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM outputs: owner's fields onto the port, grant/response routed to owner.
    always_comb begin
        mem_req_o      = mem_req_s;
        mem_addr_o     = {WORD_WIDTH{1'b0}};
        mem_we_o       = 1'b0;
        mem_be_o       = 4'h0;
        mem_wdata_o    = {WORD_WIDTH{1'b0}};
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        if (mem_req_s) begin
            if (cur_owner_s == OWNER_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
                data_gnt_o  = grant_s;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_we_o    = 1'b0;
                mem_be_o    = 4'hF;
                mem_wdata_o = {WORD_WIDTH{1'b0}};
                instr_gnt_o = grant_s;
            end
        end else begin
            mem_addr_o  = {WORD_WIDTH{1'b0}};
        end
        if (resp_s) begin
            if (owner_q == OWNER_DATA) begin
                data_rvalid_o = 1'b1;
            end else begin
                instr_rvalid_o = 1'b1;
            end
        end else begin
            data_rvalid_o  = 1'b0;
        end
    end

    // Read data goes to both masters; quiet while the arbiter is disabled.
    assign instr_rdata_o = arb_en_q ? mem_rdata_i : {WORD_WIDTH{1'b0}};
    assign data_rdata_o  = arb_en_q ? mem_rdata_i : {WORD_WIDTH{1'b0}};

    // Enable: rises on the first clock after reset release, then stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en_q <= 1'b0;
        end else begin
            arb_en_q <= 1'b1;
        end
    end

    // Owner is captured when a request leaves IDLE, granted or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWNER_INSTR;
        end else if ((state_q == ARB_IDLE) && mem_req_s) begin
            owner_q <= sel_owner_s;
        end else begin
            owner_q <= owner_q;
        end
    end

    // History for round-robin: remembers the master of every accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWNER_INSTR;
        end else if (grant_s) begin
            last_q <= cur_owner_s;
        end else begin
            last_q <= last_q;
        end
    end

endmodule
